// File: rtl/slot_desc_injector_if.sv
// slot_desc_injector_if
//   Descriptor valid/ready channel between the slot descriptor injector and
//   the RX DMA descriptor input.
//   Signals:
//     m_desc_core  : core index of the presented descriptor
//     m_desc_slot  : slot index of the presented descriptor
//     m_desc_addr  : slot address of the presented descriptor
//     m_desc_valid : descriptor valid
//     m_desc_ready : descriptor accept from the consumer
//   Modports: master (injector side), slave (DMA side).
interface slot_desc_injector_if #(
  parameter int CORE_WIDTH = 2,
  parameter int SLOT_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
);
  logic [CORE_WIDTH-1:0] m_desc_core;
  logic [SLOT_WIDTH-1:0] m_desc_slot;
  logic [ADDR_WIDTH-1:0] m_desc_addr;
  logic                  m_desc_valid;
  logic                  m_desc_ready;

  modport master (
    output m_desc_core, m_desc_slot, m_desc_addr, m_desc_valid,
    input  m_desc_ready
  );

  modport slave (
    input  m_desc_core, m_desc_slot, m_desc_addr, m_desc_valid,
    output m_desc_ready
  );
endinterface

// File: rtl/slot_desc_injector.sv
// slot_desc_injector
//   Holds a per-core slot address table with per-slot free bits, releases
//   staggered per-core go signals after a startup delay, and issues free-slot
//   RX descriptors round-robin across running cores on a valid/ready channel.
//   Optional feature macro: SLOT_DESC_STATS_EN (per-core handshake counters).
//   Ports:
//     clk, rst           : clock, asynchronous active-high reset
//     go                 : per-core run enable, sticky until reset
//     slot_addr_wr_*     : table write (core, slot, address, strobe)
//     slot_ret_*         : slot return (core, slot, strobe)
//     desc               : descriptor channel (master modport)
//     free_count         : registered total of free slots across all cores
//     err_pulse          : one-cycle illegal-operation flag
//     stat_core          : statistics read select
//     stat_count         : statistics read data (0 without the feature)
module slot_desc_injector #(
  parameter int CORE_COUNT     = 4,
  parameter int SLOT_COUNT     = 16,
  parameter int SLOT_WIDTH     = 4,
  parameter int CORE_WIDTH     = 2,
  parameter int ADDR_WIDTH     = 7,
  parameter int STARTUP_CYCLES = 1000,
  parameter int GO_STAGGER     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [CORE_COUNT-1:0]          go,
  input  logic [CORE_WIDTH-1:0]          slot_addr_wr_core,
  input  logic [SLOT_WIDTH-1:0]          slot_addr_wr_no,
  input  logic [ADDR_WIDTH-1:0]          slot_addr_wr_data,
  input  logic                           slot_addr_wr_valid,
  input  logic [CORE_WIDTH-1:0]          slot_ret_core,
  input  logic [SLOT_WIDTH-1:0]          slot_ret_no,
  input  logic                           slot_ret_valid,
  slot_desc_injector_if.master           desc,
  output logic [CORE_WIDTH+SLOT_WIDTH:0] free_count,
  output logic                           err_pulse,
  input  logic [CORE_WIDTH-1:0]          stat_core,
  output logic [15:0]                    stat_count
);
  localparam int IDX_W   = CORE_WIDTH + SLOT_WIDTH;
  localparam int NSLOT   = CORE_COUNT * SLOT_COUNT;
  localparam int CNT_MAX = STARTUP_CYCLES + (CORE_COUNT - 1) * GO_STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [NSLOT-1:0] ONE_HOT0 = {{(NSLOT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  function automatic logic [IDX_W:0] popcount(input logic [NSLOT-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < NSLOT; i++) n = n + {{IDX_W{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [SLOT_WIDTH-1:0] lowest_set(input logic [SLOT_COUNT-1:0] v);
    logic [SLOT_WIDTH-1:0] r;
    r = '0;
    for (int s = SLOT_COUNT - 1; s >= 0; s--) r = v[s] ? SLOT_WIDTH'(s) : r;
    return r;
  endfunction

  logic [CNT_W-1:0]       cnt_r;
  logic [CORE_COUNT-1:0]  go_r, go_hit_s;
  logic [NSLOT-1:0]       free_r, free_nxt_s, wr_mask_s, ret_mask_s, hs_mask_s;
  logic [ADDR_WIDTH-1:0]  addr_r [NSLOT];
  state_t                 state_r, state_nxt_s;
  logic [CORE_WIDTH-1:0]  core_r, ptr_r, sel_core_s;
  logic [SLOT_WIDTH-1:0]  slot_r, sel_slot_s;
  logic [ADDR_WIDTH-1:0]  daddr_r, sel_addr_s;
  logic [IDX_W:0]         fcnt_r;
  logic                   err_r;
  logic                   sel_found_s, load_s, hs_s, pres_s;
  logic                   wr_err_s, wr_ok_s, ret_err_s, ret_ok_s;
  logic [IDX_W-1:0]       wr_idx_s, ret_idx_s, pres_idx_s, sel_idx_s;

  assign pres_s     = (state_r == ST_PRESENT);
  assign wr_idx_s   = {slot_addr_wr_core, slot_addr_wr_no};
  assign ret_idx_s  = {slot_ret_core, slot_ret_no};
  assign pres_idx_s = {core_r, slot_r};
  assign sel_idx_s  = {sel_core_s, sel_slot_s};

  // Overwriting the presented slot would change a descriptor already on the bus.
  assign wr_err_s  = slot_addr_wr_valid && pres_s && (wr_idx_s == pres_idx_s);
  assign wr_ok_s   = slot_addr_wr_valid && !wr_err_s;
  // The presented slot keeps its free bit, so it is covered by the already-free test too.
  assign ret_err_s = slot_ret_valid && (free_r[ret_idx_s] || (pres_s && (ret_idx_s == pres_idx_s)));
  assign ret_ok_s  = slot_ret_valid && !ret_err_s;

  assign wr_mask_s  = wr_ok_s  ? (ONE_HOT0 << wr_idx_s)   : '0;
  assign ret_mask_s = ret_ok_s ? (ONE_HOT0 << ret_idx_s)  : '0;
  assign hs_mask_s  = hs_s     ? (ONE_HOT0 << pres_idx_s) : '0;
  assign free_nxt_s = (free_r | wr_mask_s | ret_mask_s) & ~hs_mask_s;

  // Startup counter saturates once the last core has been released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      go_r  <= '0;
    end else begin
      cnt_r <= (cnt_r == CNT_W'(CNT_MAX)) ? cnt_r : cnt_r + CNT_W'(1);
      go_r  <= go_r | go_hit_s;
    end
  end

  // go[i] is set on the edge at which the counter reaches its release value.
  always_comb begin
    go_hit_s = '0;
    for (int i = 0; i < CORE_COUNT; i++)
      go_hit_s[i] = (cnt_r == CNT_W'(STARTUP_CYCLES + i * GO_STAGGER - 1));
  end

  // Slot address table; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) addr_r[wr_idx_s] <= slot_addr_wr_data;
  end

  // Free bits, free-slot total and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_r <= '0;
      fcnt_r <= '0;
      err_r  <= 1'b0;
    end else begin
      free_r <= free_nxt_s;
      fcnt_r <= popcount(free_r);
      err_r  <= wr_err_s | ret_err_s;
    end
  end

  // Round-robin pick: walking from the lowest priority down lets the core at
  // the pointer overwrite last, so it wins.
  always_comb begin
    logic [CORE_WIDTH-1:0] cidx;
    logic                  elig;
    sel_found_s = 1'b0;
    sel_core_s  = '0;
    sel_slot_s  = '0;
    cidx        = '0;
    elig        = 1'b0;
    for (int off = CORE_COUNT - 1; off >= 0; off--) begin
      cidx        = CORE_WIDTH'((int'(ptr_r) + off) % CORE_COUNT);
      elig        = go_r[cidx] && (|free_r[{cidx, {SLOT_WIDTH{1'b0}}} +: SLOT_COUNT]);
      sel_found_s = sel_found_s | elig;
      sel_core_s  = elig ? cidx : sel_core_s;
      sel_slot_s  = elig ? lowest_set(free_r[{cidx, {SLOT_WIDTH{1'b0}}} +: SLOT_COUNT]) : sel_slot_s;
    end
  end

  // A table write landing on the selected slot in the same cycle supplies the address.
  assign sel_addr_s = (wr_ok_s && (wr_idx_s == sel_idx_s)) ? slot_addr_wr_data : addr_r[sel_idx_s];

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Arbiter next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    hs_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s      = sel_found_s;
        state_nxt_s = sel_found_s ? ST_PRESENT : ST_IDLE;
      end
      ST_PRESENT: begin
        hs_s        = desc.m_desc_ready;
        state_nxt_s = desc.m_desc_ready ? ST_IDLE : ST_PRESENT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Descriptor output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_r  <= '0;
      slot_r  <= '0;
      daddr_r <= '0;
      ptr_r   <= '0;
    end else begin
      if (load_s) begin
        core_r  <= sel_core_s;
        slot_r  <= sel_slot_s;
        daddr_r <= sel_addr_s;
      end
      if (hs_s) ptr_r <= (core_r == CORE_WIDTH'(CORE_COUNT - 1)) ? '0 : core_r + CORE_WIDTH'(1);
    end
  end

  assign go                = go_r;
  assign desc.m_desc_core  = core_r;
  assign desc.m_desc_slot  = slot_r;
  assign desc.m_desc_addr  = daddr_r;
  assign desc.m_desc_valid = pres_s;
  assign free_count        = fcnt_r;
  assign err_pulse         = err_r;

`ifdef SLOT_DESC_STATS_EN
  logic [15:0] stat_r [CORE_COUNT];
  logic [15:0] stat_q_r;

  // Per-core saturating handshake counters and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CORE_COUNT; i++) stat_r[i] <= 16'h0000;
      stat_q_r <= 16'h0000;
    end else begin
      if (hs_s && (stat_r[core_r] != 16'hFFFF)) stat_r[core_r] <= stat_r[core_r] + 16'h0001;
      stat_q_r <= stat_r[stat_core];
    end
  end

  assign stat_count = stat_q_r;
`else
  logic unused_stat_s;
  assign unused_stat_s = ^stat_core;
  assign stat_count    = 16'h0000;
`endif
endmodule

// File: tb/tb_slot_desc_injector.sv
// tb_slot_desc_injector
//   Self-checking bench for slot_desc_injector: expected descriptors are queued
//   as slots are written/returned and compared as the DUT hands them over.
module tb_slot_desc_injector;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] go;
  logic [1:0] slot_addr_wr_core;
  logic [3:0] slot_addr_wr_no;
  logic [6:0] slot_addr_wr_data;
  logic       slot_addr_wr_valid;
  logic [1:0] slot_ret_core;
  logic [3:0] slot_ret_no;
  logic       slot_ret_valid;
  logic [6:0] free_count;
  logic       err_pulse;
  logic [1:0] stat_core;
  logic [15:0] stat_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] core;
    logic [3:0] slot;
    logic [6:0] addr;
  } desc_t;

  typedef struct {
    int core;
    int slot;
    int addr;
  } vec_t;

  desc_t exp_q[$];
  int    stat_model [4] = '{0, 0, 0, 0};
  logic  hs_last = 1'b0;

  slot_desc_injector_if #(.CORE_WIDTH(2), .SLOT_WIDTH(4), .ADDR_WIDTH(7)) dif ();

  slot_desc_injector dut (
    .clk                (clk),
    .rst                (rst),
    .go                 (go),
    .slot_addr_wr_core  (slot_addr_wr_core),
    .slot_addr_wr_no    (slot_addr_wr_no),
    .slot_addr_wr_data  (slot_addr_wr_data),
    .slot_addr_wr_valid (slot_addr_wr_valid),
    .slot_ret_core      (slot_ret_core),
    .slot_ret_no        (slot_ret_no),
    .slot_ret_valid     (slot_ret_valid),
    .desc               (dif),
    .free_count         (free_count),
    .err_pulse          (err_pulse),
    .stat_core          (stat_core),
    .stat_count         (stat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input int c, input int s, input int a);
    desc_t d;
    d.core = 2'(c);
    d.slot = 4'(s);
    d.addr = 7'(a);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int s, input int a);
    slot_addr_wr_core  = 2'(c);
    slot_addr_wr_no    = 4'(s);
    slot_addr_wr_data  = 7'(a);
    slot_addr_wr_valid = 1'b1;
    tick();
    slot_addr_wr_valid = 1'b0;
  endtask

  task automatic ret(input int c, input int s);
    slot_ret_core  = 2'(c);
    slot_ret_no    = 4'(s);
    slot_ret_valid = 1'b1;
    tick();
    slot_ret_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("drain_pending", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Scoreboard: compare each handshake against the queued expectation and
  // require an idle cycle after every handshake.
  always @(negedge clk) begin
    desc_t d;
    if (rst) begin
      hs_last = 1'b0;
    end else begin
      if (hs_last) chk("idle_gap_valid", dif.m_desc_valid, 0);
      hs_last = dif.m_desc_valid && dif.m_desc_ready;
      if (hs_last) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_desc", 1, 0);
        end else begin
          d = exp_q.pop_front();
          chk("desc_core", dif.m_desc_core, d.core);
          chk("desc_slot", dif.m_desc_slot, d.slot);
          chk("desc_addr", dif.m_desc_addr, d.addr);
          stat_model[d.core]++;
        end
      end
    end
  end

  initial begin
    vec_t vecs [8];
    int   exp_stat;

    rst                = 1'b1;
    slot_addr_wr_core  = '0;
    slot_addr_wr_no    = '0;
    slot_addr_wr_data  = '0;
    slot_addr_wr_valid = 1'b0;
    slot_ret_core      = '0;
    slot_ret_no        = '0;
    slot_ret_valid     = 1'b0;
    stat_core          = '0;
    dif.m_desc_ready   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_go", go, 0);
    chk("rst_valid", dif.m_desc_valid, 0);
    chk("rst_core", dif.m_desc_core, 0);
    chk("rst_slot", dif.m_desc_slot, 0);
    chk("rst_addr", dif.m_desc_addr, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_stat", stat_count, 0);

    // Startup release: edge k after reset release leaves the counter at k
    rst = 1'b0;
    for (int k = 1; k <= 1060; k++) begin
      tick();
      if (k == 999)  chk("go_999", go, 4'b0000);
      if (k == 1000) chk("go_1000", go, 4'b0001);
      if (k == 1015) chk("go_1015", go, 4'b0001);
      if (k == 1016) chk("go_1016", go, 4'b0011);
      if (k == 1032) chk("go_1032", go, 4'b0111);
      if (k == 1047) chk("go_1047", go, 4'b0111);
      if (k == 1048) chk("go_1048", go, 4'b1111);
      if (k == 1060) chk("go_sticky", go, 4'b1111);
    end

    // Single descriptor, ready held high
    dif.m_desc_ready = 1'b1;
    exp_q.push_back(mk(1, 3, 'h2A));
    wr(1, 3, 'h2A);
    chk("t2_not_yet_valid", dif.m_desc_valid, 0);
    tick();
    chk("t2_valid", dif.m_desc_valid, 1);
    chk("t2_addr", dif.m_desc_addr, 'h2A);
    chk("t2_free_count_1", free_count, 1);
    tick();
    chk("t2_valid_drop", dif.m_desc_valid, 0);
    tick();
    chk("t2_free_count_0", free_count, 0);

    // Round-robin fill: table already in the expected issue order
    vecs = '{'{0, 0, 'h10}, '{2, 0, 'h40}, '{0, 1, 'h11}, '{2, 1, 'h41},
             '{0, 2, 'h12}, '{2, 2, 'h42}, '{0, 3, 'h13}, '{2, 3, 'h43}};
    dif.m_desc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(vecs[i].core, vecs[i].slot, vecs[i].addr));
      wr(vecs[i].core, vecs[i].slot, vecs[i].addr);
    end
    tick();
    chk("t3_free_count_8", free_count, 8);
    dif.m_desc_ready = 1'b1;
    drain();
    chk("t3_free_count_0", free_count, 0);

    // Write and return of the presented slot while stalled
    dif.m_desc_ready = 1'b0;
    exp_q.push_back(mk(3, 5, 'h33));
    wr(3, 5, 'h33);
    tick();
    chk("t4_valid", dif.m_desc_valid, 1);
    chk("t4_core", dif.m_desc_core, 3);
    chk("t4_slot", dif.m_desc_slot, 5);
    wr(3, 5, 'h7F);
    chk("t4_wr_err", err_pulse, 1);
    chk("t4_addr_after_wr", dif.m_desc_addr, 'h33);
    tick();
    chk("t4_err_clear", err_pulse, 0);
    chk("t4_free_count", free_count, 1);
    ret(3, 5);
    chk("t4_ret_err", err_pulse, 1);
    tick();
    chk("t4_err_clear2", err_pulse, 0);
    chk("t4_free_count2", free_count, 1);
    chk("t4_valid_held", dif.m_desc_valid, 1);
    chk("t4_addr_held", dif.m_desc_addr, 'h33);
    dif.m_desc_ready = 1'b1;
    drain();

    // Return of an already-free slot, then of an allocated slot
    dif.m_desc_ready = 1'b0;
    exp_q.push_back(mk(1, 7, 'h07));
    exp_q.push_back(mk(1, 9, 'h09));
    wr(1, 7, 'h07);
    wr(1, 9, 'h09);
    tick();
    chk("t5_free_count_2", free_count, 2);
    ret(1, 9);
    chk("t5_dup_ret_err", err_pulse, 1);
    tick();
    chk("t5_err_clear", err_pulse, 0);
    chk("t5_free_count_kept", free_count, 2);
    dif.m_desc_ready = 1'b1;
    drain();
    exp_q.push_back(mk(1, 9, 'h09));
    ret(1, 9);
    chk("t5_good_ret_no_err", err_pulse, 0);
    drain();
    chk("t5_free_count_0", free_count, 0);

    // Write and return of the same slot in one cycle
    dif.m_desc_ready   = 1'b0;
    exp_q.push_back(mk(2, 6, 'h66));
    slot_addr_wr_core  = 2'd2;
    slot_addr_wr_no    = 4'd6;
    slot_addr_wr_data  = 7'h66;
    slot_addr_wr_valid = 1'b1;
    slot_ret_core      = 2'd2;
    slot_ret_no        = 4'd6;
    slot_ret_valid     = 1'b1;
    tick();
    slot_addr_wr_valid = 1'b0;
    slot_ret_valid     = 1'b0;
    chk("t6_no_err", err_pulse, 0);
    tick();
    chk("t6_valid", dif.m_desc_valid, 1);
    chk("t6_free_count_1", free_count, 1);
    dif.m_desc_ready = 1'b1;
    drain();

    // Four more core3 descriptors, then statistics readback
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(mk(3, s, 'h50 + s));
      wr(3, s, 'h50 + s);
    end
    drain();
    stat_core = 2'd3;
    tick();
    tick();
`ifdef SLOT_DESC_STATS_EN
    exp_stat = stat_model[3];
`else
    exp_stat = 0;
`endif
    chk("stat_core3", stat_count, exp_stat);
    stat_core = 2'd1;
    tick();
    tick();
`ifdef SLOT_DESC_STATS_EN
    exp_stat = stat_model[1];
`else
    exp_stat = 0;
`endif
    chk("stat_core1", stat_count, exp_stat);

    // Reset while a descriptor is presented
    dif.m_desc_ready = 1'b0;
    wr(0, 1, 'h21);
    tick();
    chk("t7_valid_before_rst", dif.m_desc_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", dif.m_desc_valid, 0);
    chk("t7_rst_free_count", free_count, 0);
    chk("t7_rst_go", go, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
    chk("t7_post_rst_valid", dif.m_desc_valid, 0);
    chk("t7_post_rst_free_count", free_count, 0);
    chk("t7_post_rst_stat", stat_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
